// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
// One-cycle ops: ADD/SUB/AND/OR/XOR/NOT/SHL/SHR/SAR/ADC/PASS.
// Flags S/Z/P come from the registered result; Cout and Ov are registered.
// A stored carry (cy) follows the Cout of each completed op, for ADC chaining.
// Optional build macro ALU_MUL_EN adds op 12 as an unsigned shift-add
// multiplier taking WIDTH cycles. Without it, op 12 is an undefined opcode.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             S,
    output logic             Z,
    output logic             P,
    output logic             Cout,
    output logic             Ov,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SAR  = 4'd8,
        OP_ADC  = 4'd9,
        OP_PASS = 4'd10,
        OP_MUL  = 4'd12
    } op_e;

    logic             out_valid_q;
    logic [WIDTH-1:0] c_q;
    logic             cout_q;
    logic             ov_q;
    logic             cy_q;

    logic [WIDTH-1:0] c_d;
    logic             cout_d;
    logic             ov_d;
    logic [WIDTH:0]   ext;
    logic [SHW-1:0]   amt;
    logic             cin;
    logic             accept;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign busy     = busy_q;
`else
    assign in_ready = !out_valid_q || out_ready;
    assign busy     = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    // Single-cycle datapath. Arithmetic and shifts work on WIDTH+1 bits so the
    // extra bit carries Cout: bit WIDTH for add/sub/left shift, bit 0 for right shifts.
    always_comb begin
        amt    = B[SHW-1:0];
        cin    = (op == OP_ADC) ? cy_q : 1'b0;
        ext    = '0;
        c_d    = '0;
        cout_d = 1'b0;
        ov_d   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
                c_d    = ext[WIDTH-1:0];
                cout_d = ext[WIDTH];
                ov_d   = (A[MSB] == B[MSB]) && (ext[MSB] != A[MSB]);
            end
            OP_SUB: begin
                ext    = {1'b0, A} - {1'b0, B};
                c_d    = ext[WIDTH-1:0];
                cout_d = ext[WIDTH];
                ov_d   = (A[MSB] != B[MSB]) && (ext[MSB] != A[MSB]);
            end
            OP_AND:  c_d = A & B;
            OP_OR:   c_d = A | B;
            OP_XOR:  c_d = A ^ B;
            OP_NOT:  c_d = ~A;
            OP_PASS: c_d = B;
            OP_SHL: begin
                ext    = {1'b0, A} << amt;
                c_d    = ext[WIDTH-1:0];
                cout_d = ext[WIDTH];
            end
            OP_SHR: begin
                ext    = {A, 1'b0} >> amt;
                c_d    = ext[WIDTH:1];
                cout_d = ext[0];
            end
            OP_SAR: begin
                ext    = $signed({A, 1'b0}) >>> amt;
                c_d    = ext[WIDTH:1];
                cout_d = ext[0];
            end
            default: begin
                c_d    = '0;
                cout_d = 1'b0;
                ov_d   = 1'b0;
            end
        endcase
    end

    // Output register, stored carry and (optionally) the multiply sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            cout_q      <= 1'b0;
            ov_q        <= 1'b0;
            cy_q        <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
`ifdef ALU_MUL_EN
            if (state_q == ST_MUL) begin
                prod_q   <= prod_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    c_q         <= prod_step[WIDTH-1:0];
                    cout_q      <= |prod_step[2*WIDTH-1:WIDTH];
                    ov_q        <= |prod_step[2*WIDTH-1:WIDTH];
                    cy_q        <= |prod_step[2*WIDTH-1:WIDTH];
                end
            end else if (accept && (op == OP_MUL)) begin
                // in_ready guarantees any pending result is consumed on this edge
                state_q     <= ST_MUL;
                busy_q      <= 1'b1;
                mcand_q     <= {{WIDTH{1'b0}}, A};
                mplier_q    <= B;
                prod_q      <= '0;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
            end else
`endif
            if (accept) begin
                out_valid_q <= 1'b1;
                c_q         <= c_d;
                cout_q      <= cout_d;
                ov_q        <= ov_d;
                cy_q        <= cout_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign S         = c_q[MSB];
    assign Z         = (c_q == '0);
    assign P         = ~^c_q;
    assign Cout      = cout_q;
    assign Ov        = ov_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed vectors with literal expectations,
// plus a scoreboard fed by an arithmetic reference model on every cycle.
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         s, z, p, cout, ov, busy;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
        .C(c), .S(s), .Z(z), .P(p), .Cout(cout), .Ov(ov), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] c;
        bit           cout;
        bit           ov;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   cy_m;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    function automatic longint sval(input logic [W-1:0] v);
        return v[W-1] ? (longint'(v) - (longint'(1) << W)) : longint'(v);
    endfunction

    // Reference model: plain integer arithmetic on 64-bit values
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input bit ci);
        exp_t   e;
        longint ux   = longint'(x);
        longint uy   = longint'(y);
        longint sx   = sval(x);
        longint sy   = sval(y);
        longint half = longint'(1) << (W - 1);
        longint r;
        longint sr;
        longint cinv;
        int     amt  = int'(uy % W);
        e.c = '0; e.cout = 1'b0; e.ov = 1'b0;
        cinv = (o == 4'd9) ? longint'(ci) : 0;
        case (o)
            0, 9: begin
                r = ux + uy + cinv; sr = sx + sy + cinv;
                e.c = W'(r); e.cout = (r >= 2 * half); e.ov = (sr >= half) || (sr < -half);
            end
            1: begin
                r = ux - uy; sr = sx - sy;
                e.c = W'(r); e.cout = (ux < uy); e.ov = (sr >= half) || (sr < -half);
            end
            2:  e.c = x & y;
            3:  e.c = x | y;
            4:  e.c = x ^ y;
            5:  e.c = ~x;
            10: e.c = y;
            6: begin
                r = ux << amt; e.c = W'(r);
                if (amt != 0) e.cout = ((r >> W) & 1) != 0;
            end
            7: begin
                e.c = W'(ux >> amt);
                if (amt != 0) e.cout = ((ux >> (amt - 1)) & 1) != 0;
            end
            8: begin
                e.c = W'(sx >>> amt);
                if (amt != 0) e.cout = ((sx >>> (amt - 1)) & 1) != 0;
            end
            12: if (MUL_EN) begin
                r = ux * uy; e.c = W'(r); e.cout = (r >> W) != 0; e.ov = e.cout;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [20:0] pk(input exp_t e);
        logic par;
        par = ~(^e.c);
        return {e.c, e.c[W-1], e.c == 16'h0, par, e.cout, e.ov};
    endfunction

    // Scoreboard: compare displayed result every cycle, enqueue on each accept
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cy_m = 1'b0;
        end else begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else if (out_valid) begin
                chk("model_out", {c, s, z, p, cout, ov}, pk(q[0]));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                mon_e = model(op, a, b, cy_m);
                q.push_back(mon_e);
                cy_m = mon_e.cout;
            end
        end
    end

    // Issue one op, check latency to out_valid and the literal result {C,S,Z,P,Cout,Ov}
    task automatic run(input string name, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int lat, input logic [20:0] expv);
        int k;
        bit ok;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y;
        k = 0; ok = 1'b0;
        while (!ok && k < 50) begin
            @(negedge clk); k++;
            if (in_ready) ok = 1'b1;
        end
        chk({name, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0; ok = 1'b0;
        while (!ok && k < 100) begin
            @(negedge clk); k++;
            if (out_valid) ok = 1'b1;
            else if (lat > 1) begin
                chk({name, "_busy"}, busy, 1);
                chk({name, "_in_ready_low"}, in_ready, 0);
            end
        end
        chk({name, "_latency"}, k, lat);
        chk(name, {c, s, z, p, cout, ov}, expv);
    endtask

    localparam int NS = 11;
    logic [3:0]   s_op [NS] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd7, 4'd11, 4'd13, 4'd6, 4'd9, 4'd1};
    logic [W-1:0] s_a  [NS] = '{16'hf0f0, 16'hf0f0, 16'hffff, 16'h1234, 16'h0000, 16'h8003,
                                16'hbeef, 16'h0001, 16'h00ab, 16'hfffe, 16'h8000};
    logic [W-1:0] s_b  [NS] = '{16'h0ff0, 16'h0f0f, 16'haaaa, 16'h0000, 16'h5a5a, 16'h0002,
                                16'h0001, 16'h0001, 16'h0010, 16'h0001, 16'h0001};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {c, s, z, p, cout, ov}, {16'h0000, 5'b01100});
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run("add1", 4'd0, 16'h0348, 16'h354e, 1, {16'h3896, 5'b00000});
        run("add2", 4'd0, 16'h34cd, 16'hef12, 1, {16'h23df, 5'b00110});
        run("adc",  4'd9, 16'h0001, 16'h0001, 1, {16'h0003, 5'b00100});
        run("sub1", 4'd1, 16'h7fff, 16'hffff, 1, {16'h8000, 5'b10011});
        run("sub2", 4'd1, 16'h1234, 16'h1234, 1, {16'h0000, 5'b01100});
        run("shl",  4'd6, 16'h8001, 16'h0001, 1, {16'h0002, 5'b00010});
        run("sar",  4'd8, 16'h8000, 16'h000f, 1, {16'hffff, 5'b10100});
        run("op15", 4'd15, 16'h1234, 16'h5678, 1, {16'h0000, 5'b01100});

        // Backpressure: result must hold while out_ready=0, then refill with no bubble
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        chk("bp_accept", in_ready, 1);
        @(posedge clk); #1;
        op = 4'd1; a = 16'h5000; b = 16'h1000;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_value", {c, s, z, p, cout, ov}, {16'h3333, 5'b00100});
            chk("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_bubble_valid", out_valid, 1);
        chk("bp_no_bubble_value", {c, s, z, p, cout, ov}, {16'h4000, 5'b00000});

        // Back-to-back stream, checked by the scoreboard; each op must be taken in one cycle
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) begin
            in_valid = 1'b1; op = s_op[i]; a = s_a[i]; b = s_b[i];
            n = 0;
            do begin
                @(negedge clk); n++;
            end while (!in_ready && n < 50);
            chk("stream_accept_cycles", n, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_drain", q.size(), 0);

`ifdef ALU_MUL_EN
        run("mul1", 4'd12, 16'h00ff, 16'h0101, W, {16'hffff, 5'b10100});
        run("mul2", 4'd12, 16'h1000, 16'h0010, W, {16'h0000, 5'b01111});
        run("adc_after_mul", 4'd9, 16'h0001, 16'h0001, 1, {16'h0003, 5'b00100});

        // Reset in the middle of a multiply discards it
        @(posedge clk); #1;
        in_valid = 1'b1; op = 4'd12; a = 16'h0003; b = 16'h0005;
        @(negedge clk);
        chk("mulrst_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mulrst_busy_before", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mulrst_out_valid", out_valid, 0);
        chk("mulrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mulrst_no_result", out_valid, 0);
        chk("mulrst_in_ready", in_ready, 1);
        run("add_after_rst", 4'd0, 16'h0001, 16'h0002, 1, {16'h0003, 5'b00100});
`else
        run("op12_undef", 4'd12, 16'h00ff, 16'h0101, 1, {16'h0000, 5'b01100});
        chk("busy_tied_low", busy, 0);
`endif

        repeat (2) @(negedge clk);
        chk("final_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit combinational adder/flag ALU.
- Generalises the data width and adds a multi-op opcode set, valid/ready handshakes on input and output, a registered result/flag stage, and a stored carry for add-with-carry chaining.
- Sits between the operand source (register file or bench driver) and the result consumer.
- Flag semantics S, Z, P, Cout and Ov are retained.

Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 4.
- SHW, $clog2(WIDTH), number of low B bits used as the shift amount (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands and opcode valid.
- in_ready, output, 1, block can accept an operation.
- op, input, 4, opcode.
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B (shift amount for shifts).
- out_valid, output, 1, result and flags valid.
- out_ready, input, 1, consumer accepts the result.
- C, output, WIDTH, result.
- S, output, 1, sign flag: C[WIDTH-1].
- Z, output, 1, zero flag: 1 when C==0.
- P, output, 1, even parity: 1 when C has an even number of ones.
- Cout, output, 1, carry/borrow/shift-out.
- Ov, output, 1, signed overflow.
- busy, output, 1, multi-cycle operation in progress (constant 0 without ALU_MUL_EN).

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; C=0; Cout=0; Ov=0; S=0.
  - Z=1 and P=1, consistent with C=0.
  - busy=0; stored carry cy=0; FSM to IDLE.
  - Reset mid-operation discards the operation; no result is produced.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a clock edge with in_valid && in_ready.
  - Single-cycle ops: the result is registered on the accept edge, so out_valid is high from the next cycle (latency 1).
  - Output is held stable while out_valid && !out_ready.
  - out_valid drops after the edge with out_ready=1, unless a new operation is accepted on that same edge; in that case the new result replaces the old one with no bubble (full throughput).
- Opcodes. Cout=0 and Ov=0 unless stated.
  - 0 ADD: C=A+B. Cout=carry out of MSB. Ov=signed overflow.
  - 1 SUB: C=A-B. Cout=borrow (1 when A<B unsigned). Ov=signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 NOT: C=~A.
  - 6 SHL: C=A<<B[SHW-1:0]. Cout=last bit shifted out; 0 when the amount is 0.
  - 7 SHR: logical right shift. Cout as for SHL.
  - 8 SAR: arithmetic right shift. Cout as for SHL.
  - 9 ADC: C=A+B+cy. Cout and Ov as for ADD.
  - 10 PASS: C=B.
  - 12 MUL: see Optional Feature.
  - Other opcodes, including 11 and 13-15: C=0, flags derived from C. Result is still produced (out_valid pulses).
- S, Z and P are always derived from the registered C.
- cy is updated to the Cout of every completed operation, at the edge the result is registered. It is not updated by the handshake alone.
- Widths: all arithmetic is on WIDTH+1 bits; C takes the low WIDTH bits.

Optional Feature:
- Macro: ALU_MUL_EN.
- Enabled:
  - op 12 is MUL, unsigned, computed by iterative shift-add over WIDTH cycles.
  - FSM: IDLE -> MUL on accept of op 12. MUL stays for WIDTH cycles with busy=1 and in_ready=0. It returns to IDLE on the edge that registers the result, which also raises out_valid.
  - out_valid is high WIDTH cycles after the accept edge.
  - C = low WIDTH bits of the product. Cout = 1 when the upper WIDTH bits are nonzero. Ov = Cout.
  - A MUL is accepted only when the output register is free per the in_ready rule. Entering MUL while out_valid is still high is not permitted.
- Disabled: op 12 behaves as an undefined opcode; busy is tied to 0; no MUL state is built.

Test Plan (WIDTH=16):
- ADD A=0x0348, B=0x354e -> one cycle later C=0x3896, S=0, Z=0, P=0, Cout=0, Ov=0.
- ADD A=0x34cd, B=0xef12 -> C=0x23df, Cout=1, Ov=0. Then ADC A=0x0001, B=0x0001 -> C=0x0003, Cout=0.
- SUB A=0x7fff, B=0xffff -> C=0x8000, S=1, Cout=1, Ov=1. SUB A=0x1234, B=0x1234 -> C=0, Z=1, P=1.
- Backpressure:
  - Issue ADD, then hold out_ready=0 for 5 cycles -> C and flags stable, in_ready=0 throughout.
  - Raise out_ready with in_valid=1 -> back-to-back result with no bubble.
- SHL A=0x8001, B=0x0001 -> C=0x0002, Cout=1. SAR A=0x8000, B=0x000f -> C=0xffff, Cout=0. Opcode 15 -> C=0, Z=1.
- ALU_MUL_EN:
  - MUL 0x00ff × 0x0101 -> out_valid 16 cycles after accept, C=0xffff, Cout=0. busy=1 and in_ready=0 during the operation.
  - MUL 0x1000 × 0x0010 -> C=0, Z=1, Cout=1, Ov=1.
  - rst_n pulsed mid-MUL -> out_valid=0, busy=0, no result.
